// File: rtl/rx_data_path.sv
// Receive datapath: deserialises RXIn into two ping-pong word buffers and hands them out oldest-first.
// Optional parity checking is enabled by defining RX_PARITY_EN.
module rx_data_path #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartRX,
  input  logic             RXIn,
  input  logic             RXBitValid,
  input  logic             readData,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic             RXBuff0Full,
  output logic             RXBuff1Full,
  output logic             overrun,
  output logic             parityErr,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef RX_PARITY_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif
  localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Handshake: a word is transferred on every rising edge where readData and
  // dataValid are both high; readData while dataValid is low has no effect.

  state_t           state;
  logic [WIDTH-1:0] rx_buf [2];
  logic [1:0]       full;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CW-1:0]    bit_cnt;
  logic             overrun_q;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] shifted;
  logic             rd_fire;
  logic             other_busy;

  assign cur_word   = rx_buf[wr_ptr];
  assign shifted    = MSB_FIRST ? {cur_word[WIDTH-2:0], RXIn} : {RXIn, cur_word[WIDTH-1:1]};
  assign dataValid  = full[rd_ptr];
  assign rd_fire    = readData & dataValid;
  // The other buffer only blocks us if it is not being drained on this same edge.
  assign other_busy = full[~wr_ptr] & ~rd_fire;

  assign dataOut     = rx_buf[rd_ptr];
  assign RXBuff0Full = full[0];
  assign RXBuff1Full = full[1];
  assign overrun     = overrun_q;
  assign fsm_state   = state;

`ifdef RX_PARITY_EN
  logic parity_err_q;
  assign parityErr = parity_err_q;
`else
  assign parityErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_buf[0] <= '0;
      rx_buf[1] <= '0;
      full      <= 2'b00;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      bit_cnt   <= '0;
      overrun_q <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
`ifdef RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rd_fire) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end

      if (!StartRX) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        overrun_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Both buffers full is the only way the write buffer can be occupied.
            if (full[wr_ptr] && !rd_fire) state <= HOLD;
            else                          state <= FILL;
          end
          FILL: begin
            if (RXBitValid) begin
              if (bit_cnt < DATA_CNT) rx_buf[wr_ptr] <= shifted;
              if (bit_cnt == LAST_CNT) begin
                bit_cnt <= '0;
`ifdef RX_PARITY_EN
                if (^{cur_word, RXIn}) begin
                  parity_err_q <= 1'b1;
                end else begin
                  full[wr_ptr] <= 1'b1;
                  wr_ptr       <= ~wr_ptr;
                  if (other_busy) state <= HOLD;
                end
`else
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
                if (other_busy) state <= HOLD;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          HOLD: begin
            if (RXBitValid) overrun_q <= 1'b1;
            if (rd_fire)    state     <= FILL;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_data_path.sv
// Directed bench for rx_data_path: reset, single word, ping-pong, overrun, abort, same-edge commit/read, parity.
module tb_rx_data_path;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StartRX;
  logic        RXIn;
  logic        RXBitValid;
  logic        readData;
  logic [31:0] dataOut;
  logic        dataValid;
  logic        RXBuff0Full;
  logic        RXBuff1Full;
  logic        overrun;
  logic        parityErr;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_data_path #(.WIDTH(32), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .StartRX(StartRX), .RXIn(RXIn), .RXBitValid(RXBitValid),
    .readData(readData), .dataOut(dataOut), .dataValid(dataValid), .RXBuff0Full(RXBuff0Full),
    .RXBuff1Full(RXBuff1Full), .overrun(overrun), .parityErr(parityErr), .fsm_state(fsm_state)
  );

  task automatic send_bit(input logic b);
    RXIn = b; RXBitValid = 1'b1;
    @(negedge clk);
    RXBitValid = 1'b0; RXIn = 1'b0;
  endtask

  // Sends a word MSB first (plus even parity in parity builds); readData is held on the final bit if rd_last.
  task automatic send_word_rd(input logic [31:0] w, input logic rd_last);
    for (int i = 31; i >= 1; i--) send_bit(w[i]);
`ifdef RX_PARITY_EN
    send_bit(w[0]);
    readData = rd_last;
    send_bit(^w);
`else
    readData = rd_last;
    send_bit(w[0]);
`endif
    readData = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_word_rd(w, 1'b0);
  endtask

  task automatic pop();
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; StartRX = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; StartRX = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; StartRX = 1'b0; RXIn = 1'b0; RXBitValid = 1'b0; readData = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dataOut !== 32'h0) begin failures++; $display("FAIL reset_dataOut got=%h exp=%h", dataOut, 32'h0); end
    checks++; if ({dataValid, RXBuff0Full, RXBuff1Full, overrun, parityErr} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=%b", {dataValid, RXBuff0Full, RXBuff1Full, overrun, parityErr}, 5'b0); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    rst_n = 1'b1; StartRX = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [31:0] w = 32'd67;
    for (int i = 31; i >= 1; i--) send_bit(w[i]);
`ifdef RX_PARITY_EN
    send_bit(w[0]);
    checks++; if (dataValid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", dataValid); end
    send_bit(^w);
`else
    checks++; if (dataValid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", dataValid); end
    send_bit(w[0]);
`endif
    checks++; if (dataValid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", dataValid); end
    checks++; if (dataOut !== 32'h43) begin failures++; $display("FAIL single_data got=%h exp=%h", dataOut, 32'h43); end
    checks++; if ({RXBuff0Full, RXBuff1Full} !== 2'b10) begin failures++; $display("FAIL single_full got=%b exp=10", {RXBuff0Full, RXBuff1Full}); end
    pop();
    checks++; if (dataValid !== 1'b0) begin failures++; $display("FAIL single_after_read got=%b exp=0", dataValid); end
  endtask

  task automatic test_two_words();
    send_word(32'hA5A50001);
    send_word(32'h000000FF);
    checks++; if ({RXBuff0Full, RXBuff1Full} !== 2'b11) begin failures++; $display("FAIL two_full got=%b exp=11", {RXBuff0Full, RXBuff1Full}); end
    checks++; if (dataOut !== 32'hA5A50001) begin failures++; $display("FAIL two_first got=%h exp=%h", dataOut, 32'hA5A50001); end
    pop();
    checks++; if (dataOut !== 32'h000000FF || dataValid !== 1'b1) begin
      failures++; $display("FAIL two_second got=%h/%b exp=%h/1", dataOut, dataValid, 32'h000000FF); end
    pop();
    checks++; if (dataValid !== 1'b0) begin failures++; $display("FAIL two_empty got=%b exp=0", dataValid); end
    // A read with nothing valid must be ignored.
    pop();
    checks++; if ({RXBuff0Full, RXBuff1Full} !== 2'b00) begin failures++; $display("FAIL two_idle_read got=%b exp=00", {RXBuff0Full, RXBuff1Full}); end
  endtask

  task automatic test_overrun();
    send_word(32'h0F0F0F0F);
    send_word(32'hCAFEF00D);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    checks++; if (dataOut !== 32'h0F0F0F0F) begin failures++; $display("FAIL ovr_buf0 got=%h exp=%h", dataOut, 32'h0F0F0F0F); end
    pop();
    checks++; if (dataOut !== 32'hCAFEF00D) begin failures++; $display("FAIL ovr_buf1 got=%h exp=%h", dataOut, 32'hCAFEF00D); end
    StartRX = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    StartRX = 1'b1;
    @(negedge clk);
    send_word(32'h12345678);
    checks++; if (dataOut !== 32'hCAFEF00D) begin failures++; $display("FAIL ovr_order got=%h exp=%h", dataOut, 32'hCAFEF00D); end
    pop();
    checks++; if (dataOut !== 32'h12345678 || overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_new_word got=%h/%b exp=%h/0", dataOut, overrun, 32'h12345678); end
    pop();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    StartRX = 1'b0;
    @(negedge clk);
    StartRX = 1'b1;
    @(negedge clk);
    send_word(32'hDEADBEEF);
    checks++; if (dataOut !== 32'hDEADBEEF || dataValid !== 1'b1) begin
      failures++; $display("FAIL abort_word got=%h/%b exp=%h/1", dataOut, dataValid, 32'hDEADBEEF); end
    pop();
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word(32'h00C0FFEE);
    send_word_rd(32'hBEEF0123, 1'b1);
    checks++; if ({RXBuff0Full, RXBuff1Full} !== 2'b01) begin failures++; $display("FAIL b2b_full got=%b exp=01", {RXBuff0Full, RXBuff1Full}); end
    checks++; if (dataOut !== 32'hBEEF0123 || dataValid !== 1'b1) begin
      failures++; $display("FAIL b2b_data got=%h/%b exp=%h/1", dataOut, dataValid, 32'hBEEF0123); end
    pop();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(32'h00000011);
    checks++; if (RXBuff0Full !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", RXBuff0Full); end
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({dataValid, RXBuff0Full, RXBuff1Full, overrun, parityErr} !== 5'b0 || dataOut !== 32'h0) begin
      failures++; $display("FAIL rmid_outputs got=%b/%h exp=0/0", {dataValid, RXBuff0Full, RXBuff1Full, overrun, parityErr}, dataOut); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] w = 32'h67;
    do_reset();
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    send_bit(1'b0);
    checks++; if (parityErr !== 1'b1 || dataValid !== 1'b0) begin
      failures++; $display("FAIL par_bad got=%b/%b exp=1/0", parityErr, dataValid); end
    @(negedge clk);
    checks++; if (parityErr !== 1'b0) begin failures++; $display("FAIL par_pulse got=%b exp=0", parityErr); end
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    send_bit(1'b1);
    checks++; if (dataValid !== 1'b1 || dataOut !== 32'h67 || parityErr !== 1'b0) begin
      failures++; $display("FAIL par_good got=%b/%h/%b exp=1/%h/0", dataValid, dataOut, parityErr, 32'h67); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
